// File: rtl/theta_update.sv
// Serial gradient-step parameter update: teta_j -= ((h - y) * x_j) >>> SHIFT, one element per cycle.
// Optional THETA_UPDATE_ROUND_EN selects round-half-up instead of floor for the shifted product.
module theta_update #(
    parameter int DW    = 8,
    parameter int N     = 8,
    parameter int IW    = 3,
    parameter int SHIFT = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [N*DW-1:0] x,
    input  logic [N*DW-1:0] teta,
    input  logic [DW-1:0]   h,
    input  logic [DW-1:0]   y,
    output logic [N*DW-1:0] teta_out,
    output logic            busy,
    output logic            done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ERR  = 2'd1;
    localparam logic [1:0] S_UPD  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int PW = 2 * DW + 1;
    localparam int RW = 2 * DW + 2;
    localparam int MAXI = 2 ** (DW - 1) - 1;
    localparam int MINI = -(2 ** (DW - 1));
    localparam logic signed [RW-1:0] MAXV = RW'(MAXI);
    localparam logic signed [RW-1:0] MINV = RW'(MINI);

    logic [1:0]             state_q, state_d;
    logic [IW-1:0]          idx_q;
    logic signed [DW:0]     e_q;
    logic signed [DW-1:0]   h_q, y_q;
    logic signed [DW-1:0]   x_q    [N];
    logic signed [DW-1:0]   teta_q [N];
    logic [N*DW-1:0]        teta_out_q;

    logic signed [DW-1:0]   x_sel, t_sel;
    logic signed [PW-1:0]   p;
    logic signed [RW-1:0]   p_ext, d, r;
    logic signed [DW-1:0]   r_sat;
    logic                   last;

    assign last = (idx_q == IW'(N - 1));

    always_comb begin
        x_sel = x_q[idx_q];
        t_sel = teta_q[idx_q];
        p     = PW'(e_q) * PW'(x_sel);
        p_ext = RW'(p);
`ifdef THETA_UPDATE_ROUND_EN
        d     = (p_ext + (RW'(1) <<< (SHIFT - 1))) >>> SHIFT;
`else
        d     = p_ext >>> SHIFT;
`endif
        r     = RW'(t_sel) - d;
        if (r > MAXV)
            r_sat = MAXV[DW-1:0];
        else if (r < MINV)
            r_sat = MINV[DW-1:0];
        else
            r_sat = r[DW-1:0];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (enable) state_d = S_ERR;
            S_ERR:   state_d = S_UPD;
            S_UPD:   if (last) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            e_q        <= '0;
            h_q        <= '0;
            y_q        <= '0;
            teta_out_q <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                x_q[i]    <= '0;
                teta_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: if (enable) begin
                    h_q <= h;
                    y_q <= y;
                    for (int unsigned i = 0; i < N; i++) begin
                        x_q[i]    <= x[(N-1-i)*DW +: DW];
                        teta_q[i] <= teta[(N-1-i)*DW +: DW];
                    end
                end
                S_ERR: begin
                    e_q   <= (DW+1)'(h_q) - (DW+1)'(y_q);
                    idx_q <= '0;
                end
                S_UPD: begin
                    teta_q[idx_q] <= r_sat;
                    idx_q         <= idx_q + IW'(1);
                    // The final element bypasses teta_q so teta_out is whole on entry to DONE.
                    if (last) begin
                        for (int unsigned i = 0; i < N; i++)
                            teta_out_q[(N-1-i)*DW +: DW] <= (IW'(i) == idx_q) ? r_sat : teta_q[i];
                    end
                end
                default: ;
            endcase
        end
    end

    assign teta_out = teta_out_q;
    assign busy     = (state_q == S_ERR) || (state_q == S_UPD);
    assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_theta_update.sv
// Directed-vector bench for theta_update: table of hand-computed updates plus reset/handshake/throughput sequences.
module tb_theta_update;

    localparam int DW = 8;
    localparam int N  = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            enable = 1'b0;
    logic [N*DW-1:0] x = '0, teta = '0;
    logic [DW-1:0]   h = '0, y = '0;
    logic [N*DW-1:0] teta_out;
    logic            busy, done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    theta_update #(.DW(8), .N(8), .IW(3), .SHIFT(3)) dut (
        .clk(clk), .reset(reset), .enable(enable), .x(x), .teta(teta),
        .h(h), .y(y), .teta_out(teta_out), .busy(busy), .done(done)
    );

    typedef struct {
        logic [63:0] xv;
        logic [63:0] tv;
        int          hv;
        int          yv;
        logic [63:0] exp_v;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [63:0] pk(input int e0, e1, e2, e3, e4, e5, e6, e7);
        logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7;
        b0 = e0[7:0]; b1 = e1[7:0]; b2 = e2[7:0]; b3 = e3[7:0];
        b4 = e4[7:0]; b5 = e5[7:0]; b6 = e6[7:0]; b7 = e7[7:0];
        return {b0, b1, b2, b3, b4, b5, b6, b7};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp_v);
        n_cmp++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp_v);
        end
    endtask

    // Pulses enable for one capture edge and waits (bounded) for done; lat = edges from capture to done.
    task automatic run_op(input logic [63:0] xv, tv, input int hv, yv,
                          output logic [63:0] res, output int lat);
        @(negedge clk);
        x = xv; teta = tv; h = hv[7:0]; y = yv[7:0]; enable = 1'b1;
        @(posedge clk);
        #1 enable = 1'b0;
        chk("busy_after_capture", 64'(busy), 64'd1);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        res = teta_out;
        if (lat >= 40) chk("done_timeout", 64'(done), 64'd1);
        else chk("busy_in_done", 64'(busy), 64'd0);
        @(posedge clk);
        #1 chk("done_one_cycle", 64'(done), 64'd0);
    endtask

    logic [63:0] res;
    int lat;
    int times[$];
    int cyc;
    logic done_prev;

    initial begin
        vecs[0] = '{pk(2,2,2,2,2,2,2,2), pk(4,4,4,4,4,4,4,4), 10, 2, pk(2,2,2,2,2,2,2,2)};
        vecs[1] = '{pk(5,-3,100,-128,127,0,1,-1), pk(10,-20,127,-128,0,55,-7,3), 37, 37,
                    pk(10,-20,127,-128,0,55,-7,3)};
`ifdef THETA_UPDATE_ROUND_EN
        vecs[2] = '{pk(127,-127,0,1,-1,2,-2,4), pk(-120,120,7,50,-50,0,0,-1), 127, -128,
                    pk(-128,127,7,18,-18,-64,64,-128)};
        vecs[3] = '{pk(3,3,3,3,3,3,3,3), pk(5,5,5,5,5,5,5,5), 0, 1, pk(5,5,5,5,5,5,5,5)};
`else
        vecs[2] = '{pk(127,-127,0,1,-1,2,-2,4), pk(-120,120,7,50,-50,0,0,-1), 127, -128,
                    pk(-128,127,7,19,-18,-63,64,-128)};
        vecs[3] = '{pk(3,3,3,3,3,3,3,3), pk(5,5,5,5,5,5,5,5), 0, 1, pk(6,6,6,6,6,6,6,6)};
`endif
        vecs[4] = '{pk(1,2,3,-4,16,-16,0,7), pk(0,0,0,0,0,0,100,-100), -5, 3,
                    pk(1,2,3,-4,16,-16,100,-93)};
        vecs[5] = '{pk(-128,127,0,0,0,0,0,0), pk(0,0,9,9,9,9,9,9), -128, 127,
                    pk(-128,127,9,9,9,9,9,9)};

        #12;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_teta_out", teta_out, 64'd0);
        @(negedge clk) reset = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].xv, vecs[i].tv, vecs[i].hv, vecs[i].yv, res, lat);
            chk($sformatf("vec%0d_teta_out", i), res, vecs[i].exp_v);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(N + 1));
        end

        // Reset while idx=3: four edges after the capture edge.
        @(negedge clk);
        x = vecs[0].xv; teta = vecs[0].tv; h = 8'd10; y = 8'd2; enable = 1'b1;
        @(posedge clk);
        #1 enable = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_teta_out", teta_out, 64'd0);
        @(negedge clk) reset = 1'b1;
        done_prev = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1 if (done) done_prev = 1'b1;
        end
        chk("midrst_no_stale_done", 64'(done_prev), 64'd0);
        run_op(vecs[4].xv, vecs[4].tv, vecs[4].hv, vecs[4].yv, res, lat);
        chk("midrst_recover", res, vecs[4].exp_v);

        // Operand/enable changes while busy must not disturb the captured operation.
        @(negedge clk);
        x = vecs[0].xv; teta = vecs[0].tv; h = 8'd10; y = 8'd2; enable = 1'b1;
        @(posedge clk);
        #1;
        x = vecs[2].xv; teta = vecs[2].tv; h = 8'd127; y = 8'h80;
        lat = 0;
        while (!done && lat < 40) begin
            enable = ~enable;
            @(posedge clk);
            #1 lat++;
        end
        enable = 1'b0;
        chk("hs_latency", 64'(lat), 64'(N + 1));
        chk("hs_teta_out", teta_out, vecs[0].exp_v);
        repeat (3) @(posedge clk);

        // Back-to-back operations with enable held high.
        @(negedge clk);
        x = vecs[0].xv; teta = vecs[0].tv; h = 8'd10; y = 8'd2; enable = 1'b1;
        cyc = 0;
        done_prev = 1'b0;
        while (cyc < 60) begin
            @(posedge clk);
            #1 cyc++;
            if (done && !done_prev) times.push_back(cyc);
            done_prev = done;
        end
        enable = 1'b0;
        chk("tp_pulse_count_ge3", 64'(times.size() >= 3), 64'd1);
        if (times.size() >= 3) begin
            chk("tp_interval1", 64'(times[1] - times[0]), 64'd11);
            chk("tp_interval2", 64'(times[2] - times[1]), 64'd11);
        end
        chk("tp_teta_out", teta_out, vecs[0].exp_v);
        repeat (15) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
